// File: rtl/data_mem_sized.sv
// Byte-addressable big-endian data memory for the MEM stage: byte/half/word
// accesses, registered loads, alignment/range rejection and a post-reset clear.

module data_mem_sized_lane #(
    parameter int AW   = 6,
    parameter int LANE = 0
) (
    input  logic [AW-1:0] idx,
    input  logic [2:0]    nb,
    input  logic [31:0]   wdata,
    input  logic          st_en,
    input  logic          init_en,
    input  logic [AW-1:0] init_base,
    output logic [AW-1:0] addr,
    output logic [7:0]    wbyte,
    output logic          we
);
    logic        active;
    logic [4:0]  sh;
    logic [31:0] shifted;

    // Lane k carries the k-th byte from the low address, which is the most
    // significant stored byte (big-endian).
    always_comb begin
        active  = (3'(LANE) < nb);
        sh      = active ? 5'(8 * (int'(nb) - 1 - LANE)) : 5'd0;
        shifted = wdata >> sh;
        addr    = init_en ? init_base + AW'(LANE) : idx + AW'(LANE);
        wbyte   = init_en ? 8'h00 : shifted[7:0];
        we      = init_en || (st_en && active);
    end
endmodule

module data_mem_sized #(
    parameter int ERR_W          = 8,
    parameter int DEPTH          = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic [31:0]      Address,
    input  logic [31:0]      writeData,
    input  logic             Read,
    input  logic             Write,
    input  logic [1:0]       Size,
    input  logic             Unsigned,
    output logic [31:0]      dataOut,
    output logic             dataValid,
    output logic             Busy,
    output logic             Misaligned,
    output logic             OutOfRange,
    output logic [ERR_W-1:0] ErrCount
);
    localparam int AW        = $clog2(DEPTH);
    localparam int PW        = (AW > 2) ? AW - 2 : 1;
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int STAGES    = 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH / 4 - 1);

    typedef enum logic {S_INIT, S_IDLE} state_t;

    typedef struct packed {
        logic       req;
        logic       mis;
        logic       oor;
        logic       st;
        logic       ld;
        logic [2:0] nb;
    } dec_t;

    state_t state, nstate;
    dec_t   dec;
    logic [PW-1:0]   ptr;
    logic            init_en;
    logic [AW-1:0]   init_base;
    logic [32:0]     last_byte;
    logic [31:0]     ld_val;
    logic [STAGES:0] vld_pipe;

    logic [VEC_W-1:0] mem [DEPTH];

    logic [NUM_LANES-1:0][AW-1:0]    lane_addr;
    logic [NUM_LANES-1:0][VEC_W-1:0] lane_wbyte;
    logic [NUM_LANES-1:0][VEC_W-1:0] rbyte;
    logic [NUM_LANES-1:0]            lane_we;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state <= CLEAR_ON_RESET ? S_INIT : S_IDLE;
        else          state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (state == S_INIT && ptr == LAST) nstate = S_IDLE;
    end

    always_comb begin
        Busy      = (state == S_INIT);
        init_en   = (state == S_INIT);
        init_base = AW'({ptr, 2'b00});
    end

    // Misalignment outranks range so a bad access raises exactly one flag.
    always_comb begin
        dec.nb    = (Size == 2'b00) ? 3'd1 : (Size == 2'b01) ? 3'd2 : 3'd4;
        dec.req   = (state == S_IDLE) && (Read || Write);
        dec.mis   = (Size == 2'b11) || (Size == 2'b01 && Address[0]) ||
                    (Size == 2'b10 && Address[1:0] != 2'b00);
        last_byte = {1'b0, Address} + 33'(dec.nb) - 33'd1;
        dec.oor   = !dec.mis && (last_byte >= 33'(DEPTH));
        dec.st    = dec.req && !dec.mis && !dec.oor && Write;
        dec.ld    = dec.req && !dec.mis && !dec.oor && !Write;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        data_mem_sized_lane #(.AW(AW), .LANE(k)) u_lane (
            .idx       (Address[AW-1:0]),
            .nb        (dec.nb),
            .wdata     (writeData),
            .st_en     (dec.st),
            .init_en   (init_en),
            .init_base (init_base),
            .addr      (lane_addr[k]),
            .wbyte     (lane_wbyte[k]),
            .we        (lane_we[k])
        );
        assign rbyte[k] = mem[lane_addr[k]];
    end

    always_ff @(posedge CLK) begin
        for (int k = 0; k < NUM_LANES; k++)
            if (lane_we[k]) mem[lane_addr[k]] <= lane_wbyte[k];
    end

    always_comb begin
        case (Size)
            2'b00:   ld_val = {{24{~Unsigned & rbyte[0][7]}}, rbyte[0]};
            2'b01:   ld_val = {{16{~Unsigned & rbyte[0][7]}}, rbyte[0], rbyte[1]};
            default: ld_val = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
        endcase
    end

    assign vld_pipe[0] = dec.ld;
    assign dataValid   = vld_pipe[STAGES];

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_pipe[STAGES:1] <= '0;
            dataOut            <= '0;
            Misaligned         <= 1'b0;
            OutOfRange         <= 1'b0;
            ErrCount           <= '0;
            ptr                <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            Misaligned         <= dec.req && dec.mis;
            OutOfRange         <= dec.req && dec.oor;
            if (dec.ld) dataOut <= ld_val;
            if (dec.req && (dec.mis || dec.oor) && ErrCount != {ERR_W{1'b1}})
                ErrCount <= ErrCount + 1'b1;
            if (init_en) ptr <= ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_data_mem_sized.sv
// Random and directed checks of data_mem_sized against a byte-array model;
// a second instance with a 2-bit error counter checks saturation.

module tb_data_mem_sized;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, wdata;
    logic        rd, wr, uns;
    logic [1:0]  size;

    logic [31:0] dout, dout_s;
    logic        vld, busy, mis, oor;
    logic        vld_s, busy_s, mis_s, oor_s;
    logic [7:0]  err;
    logic [1:0]  err_s;

    int n_cmp = 0;
    int n_bad = 0;

    byte unsigned m [64];
    logic [31:0]  e_dout;
    int           e_err;
    bit           e_vld, e_mis, e_oor;

    always #5 clk = ~clk;

    data_mem_sized u_dut (
        .CLK(clk), .Reset_n(rst_n), .Address(addr), .writeData(wdata),
        .Read(rd), .Write(wr), .Size(size), .Unsigned(uns),
        .dataOut(dout), .dataValid(vld), .Busy(busy),
        .Misaligned(mis), .OutOfRange(oor), .ErrCount(err)
    );

    data_mem_sized #(.ERR_W(2)) u_sat (
        .CLK(clk), .Reset_n(rst_n), .Address(addr), .writeData(wdata),
        .Read(rd), .Write(wr), .Size(size), .Unsigned(uns),
        .dataOut(dout_s), .dataValid(vld_s), .Busy(busy_s),
        .Misaligned(mis_s), .OutOfRange(oor_s), .ErrCount(err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void model(bit r, bit w, bit [1:0] s, bit u, logic [31:0] a, logic [31:0] d);
        longint nb, v;
        bit     bad_align, bad_range;
        e_vld = 0; e_mis = 0; e_oor = 0;
        if (!(r || w)) return;
        nb        = (s == 0) ? 1 : (s == 1) ? 2 : 4;
        bad_align = (s == 3) || (s == 1 && a[0]) || (s == 2 && a[1:0] != 0);
        bad_range = !bad_align && ({32'b0, a} + nb - 1 >= 64);
        if (bad_align || bad_range) begin
            e_mis = bad_align; e_oor = bad_range; e_err++;
        end else if (w) begin
            for (int i = 0; i < nb; i++)
                m[int'(a[5:0]) + i] = 8'(d >> (8 * (nb - 1 - i)));
        end else begin
            v = 0;
            for (int i = 0; i < nb; i++) v = (v << 8) | longint'(m[int'(a[5:0]) + i]);
            if (!u && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1)
                v = v - (longint'(1) << (8 * nb));
            e_dout = 32'(v);
            e_vld  = 1;
        end
    endfunction

    function automatic logic [31:0] sat(int x, int mx);
        return (x > mx) ? 32'(mx) : 32'(x);
    endfunction

    task automatic check_outs();
        chk("dataValid",  {31'b0, vld},  {31'b0, e_vld});
        chk("Misaligned", {31'b0, mis},  {31'b0, e_mis});
        chk("OutOfRange", {31'b0, oor},  {31'b0, e_oor});
        chk("dataOut",    dout,          e_dout);
        chk("ErrCount",   {24'b0, err},  sat(e_err, 255));
        chk("ErrCount_w2", {30'b0, err_s}, sat(e_err, 3));
        chk("Busy",       {31'b0, busy}, 32'd0);
    endtask

    task automatic op(bit r, bit w, bit [1:0] s, bit u, logic [31:0] a, logic [31:0] d);
        rd = r; wr = w; size = s; uns = u; addr = a; wdata = d;
        @(negedge clk);
        model(r, w, s, u, a, d);
        check_outs();
        rd = 0; wr = 0;
    endtask

    task automatic reset_seq(int abort_at);
        int n;
        bit noisy;
        rd = 0; wr = 0; rst_n = 1'b0;
        #2;
        chk("rst_dataOut", dout, 32'd0);
        chk("rst_flags", {29'b0, vld, mis, oor}, 32'd0);
        chk("rst_ErrCount", {24'b0, err}, 32'd0);
        chk("rst_Busy", {31'b0, busy}, 32'd1);
        @(negedge clk) rst_n = 1'b1;
        if (abort_at > 0) begin
            repeat (abort_at) @(negedge clk);
            chk("mid_Busy", {31'b0, busy}, 32'd1);
            rst_n = 1'b0;
            #2;
            chk("abort_Busy", {31'b0, busy}, 32'd1);
            @(negedge clk) rst_n = 1'b1;
        end
        n = 0; noisy = 0;
        rd = 1; wr = 0; size = 2; addr = 0;
        while (busy && n < 100) begin
            if (vld || mis || oor || err != 0) noisy = 1;
            n++;
            @(negedge clk);
        end
        rd = 0;
        chk("init_cycles", 32'(n), 32'd16);
        chk("init_quiet", {31'b0, noisy}, 32'd0);
        foreach (m[i]) m[i] = 0;
        e_dout = 0; e_err = 0; e_vld = 0; e_mis = 0; e_oor = 0;
    endtask

    initial begin
        rd = 0; wr = 0; size = 0; uns = 0; addr = 0; wdata = 0;
        reset_seq(0);
        for (int i = 0; i < 16; i++) op(1, 0, 2, 0, 32'(i * 4), 0);

        op(0, 1, 2, 0, 8, 32'h8123_45F6);
        for (int i = 8; i < 12; i++) op(1, 0, 0, 0, 32'(i), 0);
        for (int i = 8; i < 12; i++) op(1, 0, 0, 1, 32'(i), 0);
        op(0, 1, 1, 0, 2, 32'h0000_BEEF);
        op(1, 0, 2, 0, 0, 0);
        op(1, 0, 1, 0, 2, 0);
        op(1, 0, 1, 1, 2, 0);

        op(1, 0, 2, 0, 6, 0);
        op(0, 1, 2, 0, 64, 32'hDEAD_BEEF);
        op(1, 0, 2, 0, 60, 0);
        op(1, 0, 3, 0, 0, 0);
        op(1, 1, 2, 0, 12, 32'h1122_3344);
        op(1, 0, 2, 0, 12, 0);
        op(1, 0, 1, 0, 63, 0);
        op(1, 0, 0, 0, 32'hFFFF_FFFF, 0);
        op(0, 1, 0, 0, 63, 32'h0000_00A5);
        op(1, 0, 0, 0, 63, 0);

        for (int i = 0; i < 400; i++) begin
            int code;
            logic [31:0] a;
            code = $urandom_range(0, 3);
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 70));
            op(code[0], code[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int i = 0; i < 16; i++) op(0, 1, 2, 0, 32'(i * 4), $urandom | 32'h1);
        reset_seq(7);
        for (int i = 0; i < 16; i++) op(1, 0, 2, 0, 32'(i * 4), 0);
        for (int i = 0; i < 100; i++) begin
            int code;
            code = $urandom_range(0, 3);
            op(code[0], code[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               32'($urandom_range(0, 66)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
